regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the 24-entry × 24-bit register file's single write port. It accepts write requests from two producers, the ALU result path and the load-data path. Each producer gets a one-entry holding buffer with a valid/ready handshake. Every cycle the block grants at most one held request onto the register-file write port, preserving write order to the same register and bounding ALU starvation. It also exports a per-register pending-write scoreboard for hazard/stall logic in the decode stage.

## Interface
- NUM_REGS, 24, register-file depth; valid indices 0..NUM_REGS-1
- DATA_W, 24, data width
- STARVE_LIMIT, 3, consecutive lost-arbitration cycles after which the held ALU request is forced through
- Clock  input  1  single clock, rising edge
- Reset_n  input  1  asynchronous, active-low reset
- AluValid  input  1  ALU write request
- AluRd  input  5  ALU destination index
- AluData  input  DATA_W  ALU write data
- AluReady  output  1  ALU holding buffer can accept
- LdValid  input  1  load write request
- LdRd  input  5  load destination index
- LdData  input  DATA_W  load write data
- LdReady  output  1  load holding buffer can accept
- RegWrite  output  1  write strobe to register file
- RD  output  5  write index to register file
- WriteData  output  DATA_W  write data to register file
- QueryRS, QueryRT  input  5 each  decode-stage source indices
- BusyRS, BusyRT  output  1 each  queried register has a held, unwritten request
- BusyVec  output  NUM_REGS  pending-write scoreboard, bit i = register i pending
- BadAddr  output  1  sticky: a request with index ≥ NUM_REGS was accepted

## Operation
- Handshake: transfer occurs on a rising edge with Valid && Ready. Valid and payload must hold until transfer.
- Ready = holding buffer empty, or buffer granted in the current cycle (same-cycle drain and refill).
- Captured index ≥ NUM_REGS: BadAddr is set. The entry is discarded at capture, never held or written.
- Grant selection, evaluated in priority order when both buffers are held:
  - 1. Same Rd in both buffers: grant the older entry. The age bit is set at capture. When both capture in the same cycle, Load is older.
  - 2. ALU starve counter == STARVE_LIMIT: grant ALU.
  - 3. Otherwise grant Load.
- Only one buffer held: grant it.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) each cycle ALU is held but not granted;
  - clears on ALU grant or when the ALU buffer is empty.
- Write port:
  - RegWrite = 1 in any cycle a grant occurs; RD/WriteData come from the granted buffer.
  - With no grant, RegWrite = 0 and RD = 0. WriteData holds its last value.
- Scoreboard:
  - BusyVec bit set for each held buffer's Rd; computed from state only.
  - BusyRS = BusyVec[QueryRS] and BusyRT = BusyVec[QueryRT]. Each is 0 for a query index ≥ NUM_REGS.
- Reset (asserted at any time, including mid-transfer):
  - both buffers empty; held requests are dropped;
  - starve counter 0, age bit 0, BadAddr 0;
  - RegWrite 0, RD 0, WriteData 0, BusyVec 0;
  - AluReady = LdReady = 1 after reset release.

## Timing
- Capture at edge N, write visible on port during cycle N+1 (earliest). Register file commits at edge N+1.
- Maximum occupancy is 2 held requests. Sustained throughput is 1 write/cycle.
- Both producers streaming every cycle: Load drains every cycle. ALU waits STARVE_LIMIT cycles, then wins one cycle, and LdReady = 0 in that cycle.
- No combinational path from AluValid/LdValid/payload to RegWrite/RD/WriteData/BusyVec.
- Ready depends only on state.
- BusyRS/BusyRT are combinational from Query* and state.

## Structure
- Shared package (cpu_pkg): NUM_REGS, DATA_W, register-index width (5), and a write-request struct {valid, rd, data, age}.
- One sub-module, wb_hold_buf, instantiated twice. It contains the one-entry holding buffer, the handshake, range check, age capture and Rd decode to a NUM_REGS one-hot.
- Grant logic, starve counter and write-port mux live in the top level.

## Test plan
- Reset: assert Reset_n = 0 mid-stream with both buffers held. Required: RegWrite = 0, BusyVec = 0, BadAddr = 0, both Ready = 1 after release, and neither held value is ever written.
- Single ALU write: AluRd = 5, AluData = 0x00ABCD at edge N. Required: cycle N+1 has RegWrite = 1, RD = 5, WriteData = 0x00ABCD; BusyVec[5] = 1 during N+1, 0 at N+2.
- Same-Rd ordering: Load Rd = 7 (0x111111) captured at N, ALU Rd = 7 (0x222222) captured at N+1. Required: 0x111111 is written first, then 0x222222. Also capture both in the same cycle; Load is written first.
- Starvation: both producers valid every cycle, distinct Rd, STARVE_LIMIT = 3. Required: Load granted 3 consecutive cycles, ALU granted on the 4th, then the pattern repeats.
- Bad address: LdRd = 24. Required: LdReady stays 1, no RegWrite for that request, BadAddr = 1 until reset.
- Scoreboard query: ALU Rd = 3 held, QueryRS = 3, QueryRT = 4. Required: BusyRS = 1, BusyRT = 0. With QueryRT = 30, BusyRT = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared write-back types and sizing for the register-file write-port arbiter.
package cpu_pkg;

   localparam int unsigned NUM_REGS     = 24;
   localparam int unsigned DATA_W       = 24;
   localparam int unsigned RIDX_W       = 5;
   localparam int unsigned STARVE_LIMIT = 3;
   localparam int unsigned STARVE_W     = 2;

   // age = 1 marks the entry as the younger of two held entries
   typedef struct packed {
      logic              valid;
      logic [RIDX_W-1:0] rd;
      logic [DATA_W-1:0] data;
      logic              age;
   } wb_req_t;

   function automatic logic rd_in_range(input logic [RIDX_W-1:0] rd);
      return rd < RIDX_W'(NUM_REGS);
   endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry write-request holding buffer with valid/ready handshake,
// destination range check, relative-age capture and one-hot Rd decode.
module wb_hold_buf
   import cpu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [RIDX_W-1:0]   in_rd,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                grant,
   input  logic                younger,
   input  logic                peer_drain,
   output logic                ready_c,
   output logic                cap_bad_c,
   output wb_req_t             req,
   output logic [NUM_REGS-1:0] onehot_c
);

   logic cap;
   logic in_ok;

   assign ready_c   = !req.valid || grant;
   assign cap       = in_valid && ready_c;
   assign in_ok     = rd_in_range(in_rd);
   assign cap_bad_c = cap && !in_ok;

   // Out-of-range requests are swallowed at capture and never held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req <= '0;
      end else if (cap) begin
         req.valid <= in_ok;
         req.rd    <= in_rd;
         req.data  <= in_data;
         req.age   <= younger && in_ok;
      end else if (grant) begin
         req.valid <= 1'b0;
         req.age   <= 1'b0;
      end else if (peer_drain) begin
         req.age   <= 1'b0;
      end
   end

   always_comb begin
      onehot_c = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         onehot_c[i] = req.valid && (req.rd == RIDX_W'(i));
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: ALU and load holding buffers share the register-file
// write port with same-Rd ordering, bounded ALU starvation and a busy scoreboard.
module regfile_wb_arbiter
   import cpu_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                AluValid,
   input  logic [RIDX_W-1:0]   AluRd,
   input  logic [DATA_W-1:0]   AluData,
   output logic                AluReady,
   input  logic                LdValid,
   input  logic [RIDX_W-1:0]   LdRd,
   input  logic [DATA_W-1:0]   LdData,
   output logic                LdReady,
   output logic                RegWrite,
   output logic [RIDX_W-1:0]   RD,
   output logic [DATA_W-1:0]   WriteData,
   input  logic [RIDX_W-1:0]   QueryRS,
   input  logic [RIDX_W-1:0]   QueryRT,
   output logic                BusyRS,
   output logic                BusyRT,
   output logic [NUM_REGS-1:0] BusyVec,
   output logic                BadAddr
);

   wb_req_t               alu_q;
   wb_req_t               ld_q;
   logic                  alu_gnt;
   logic                  ld_gnt;
   logic                  alu_younger;
   logic                  ld_younger;
   logic                  alu_bad;
   logic                  ld_bad;
   logic [NUM_REGS-1:0]   alu_oh;
   logic [NUM_REGS-1:0]   ld_oh;
   logic [STARVE_W-1:0]   starve_q;
   logic [DATA_W-1:0]     wd_q;
   logic                  bad_q;

   // A newly captured entry is younger than any entry the peer keeps past this edge.
   assign alu_younger = (ld_q.valid && !ld_gnt) ||
                        (LdValid && LdReady && rd_in_range(LdRd));
   assign ld_younger  = alu_q.valid && !alu_gnt;

   wb_hold_buf u_alu_buf (
      .clk        (Clock),
      .rst_n      (Reset_n),
      .in_valid   (AluValid),
      .in_rd      (AluRd),
      .in_data    (AluData),
      .grant      (alu_gnt),
      .younger    (alu_younger),
      .peer_drain (ld_gnt),
      .ready_c    (AluReady),
      .cap_bad_c  (alu_bad),
      .req        (alu_q),
      .onehot_c   (alu_oh)
   );

   wb_hold_buf u_ld_buf (
      .clk        (Clock),
      .rst_n      (Reset_n),
      .in_valid   (LdValid),
      .in_rd      (LdRd),
      .in_data    (LdData),
      .grant      (ld_gnt),
      .younger    (ld_younger),
      .peer_drain (alu_gnt),
      .ready_c    (LdReady),
      .cap_bad_c  (ld_bad),
      .req        (ld_q),
      .onehot_c   (ld_oh)
   );

   // Grant selection from held state only: same-Rd age, then starvation, then Load.
   always_comb begin
      alu_gnt = 1'b0;
      ld_gnt  = 1'b0;
      if (alu_q.valid && ld_q.valid) begin
         if (alu_q.rd == ld_q.rd) begin
            if (ld_q.age && !alu_q.age) alu_gnt = 1'b1;
            else                        ld_gnt  = 1'b1;
         end else if (starve_q == STARVE_W'(STARVE_LIMIT)) begin
            alu_gnt = 1'b1;
         end else begin
            ld_gnt = 1'b1;
         end
      end else if (alu_q.valid) begin
         alu_gnt = 1'b1;
      end else if (ld_q.valid) begin
         ld_gnt = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         starve_q <= '0;
      end else if (alu_q.valid && !alu_gnt) begin
         if (starve_q != STARVE_W'(STARVE_LIMIT)) starve_q <= starve_q + STARVE_W'(1);
      end else begin
         starve_q <= '0;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wd_q  <= '0;
         bad_q <= 1'b0;
      end else begin
         if (alu_gnt)     wd_q <= alu_q.data;
         else if (ld_gnt) wd_q <= ld_q.data;
         if (alu_bad || ld_bad) bad_q <= 1'b1;
      end
   end

   // Write port: granted entry shows in the same cycle, data holds when idle.
   always_comb begin
      RegWrite  = alu_gnt || ld_gnt;
      RD        = '0;
      WriteData = wd_q;
      if (alu_gnt) begin
         RD        = alu_q.rd;
         WriteData = alu_q.data;
      end else if (ld_gnt) begin
         RD        = ld_q.rd;
         WriteData = ld_q.data;
      end
   end

   assign BusyVec = alu_oh | ld_oh;
   assign BadAddr = bad_q;

   always_comb begin
      BusyRS = 1'b0;
      BusyRT = 1'b0;
      if (rd_in_range(QueryRS)) BusyRS = BusyVec[QueryRS];
      if (rd_in_range(QueryRT)) BusyRT = BusyVec[QueryRT];
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, starvation and reset sequences,
// then random traffic against a sequence-number reference model.
module tb_regfile_wb_arbiter;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        AluValid = 1'b0;
   logic [4:0]  AluRd = '0;
   logic [23:0] AluData = '0;
   logic        AluReady;
   logic        LdValid = 1'b0;
   logic [4:0]  LdRd = '0;
   logic [23:0] LdData = '0;
   logic        LdReady;
   logic        RegWrite;
   logic [4:0]  RD;
   logic [23:0] WriteData;
   logic [4:0]  QueryRS = '0;
   logic [4:0]  QueryRT = '0;
   logic        BusyRS;
   logic        BusyRT;
   logic [23:0] BusyVec;
   logic        BadAddr;

   int checks = 0;
   int failures = 0;

   regfile_wb_arbiter dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
      .LdValid(LdValid), .LdRd(LdRd), .LdData(LdData), .LdReady(LdReady),
      .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
      .QueryRS(QueryRS), .QueryRT(QueryRT), .BusyRS(BusyRS), .BusyRT(BusyRT),
      .BusyVec(BusyVec), .BadAddr(BadAddr)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        av; logic [4:0] ar; logic [23:0] ad;
      logic        lv; logic [4:0] lr; logic [23:0] ld;
      logic [4:0]  qs; logic [4:0] qt;
      logic        we; logic [4:0] erd; logic [23:0] ewd;
      logic        ear; logic elr; logic [23:0] ebv;
      logic        ebs; logic ebt; logic ebad;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic av, input int ar, input int ad,
                               input logic lv, input int lr, input int ld,
                               input int qs, input int qt,
                               input logic we, input int erd, input int ewd,
                               input logic ear, input logic elr, input int ebv,
                               input logic ebs, input logic ebt, input logic ebad);
      vec_t v;
      v.av = av; v.ar = 5'(ar); v.ad = 24'(ad);
      v.lv = lv; v.lr = 5'(lr); v.ld = 24'(ld);
      v.qs = 5'(qs); v.qt = 5'(qt);
      v.we = we; v.erd = 5'(erd); v.ewd = 24'(ewd);
      v.ear = ear; v.elr = elr; v.ebv = 24'(ebv);
      v.ebs = ebs; v.ebt = ebt; v.ebad = ebad;
      return v;
   endfunction

   task automatic check_all(input string tag, input logic we, input logic [4:0] erd,
                            input logic [23:0] ewd, input logic ear, input logic elr,
                            input logic [23:0] ebv, input logic ebs, input logic ebt,
                            input logic ebad);
      chk({tag, " RegWrite"}, 32'(RegWrite), 32'(we));
      chk({tag, " RD"}, 32'(RD), 32'(erd));
      chk({tag, " WriteData"}, 32'(WriteData), 32'(ewd));
      chk({tag, " AluReady"}, 32'(AluReady), 32'(ear));
      chk({tag, " LdReady"}, 32'(LdReady), 32'(elr));
      chk({tag, " BusyVec"}, 32'(BusyVec), 32'(ebv));
      chk({tag, " BusyRS"}, 32'(BusyRS), 32'(ebs));
      chk({tag, " BusyRT"}, 32'(BusyRT), 32'(ebt));
      chk({tag, " BadAddr"}, 32'(BadAddr), 32'(ebad));
   endtask

   task automatic idle_inputs();
      AluValid = 1'b0; LdValid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      idle_inputs();
      Reset_n = 1'b0;
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   // Reference model: two slots ordered by capture sequence numbers.
   logic        m_v[2];
   logic [4:0]  m_rd[2];
   logic [23:0] m_dat[2];
   int          m_seq[2];
   int          m_next_seq;
   int          m_starve;
   logic [23:0] m_wd;
   logic        m_bad;

   function automatic int model_grant();  // -1 none, 0 ALU, 1 Load
      if (m_v[0] && m_v[1]) begin
         if (m_rd[0] == m_rd[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
         return (m_starve >= 3) ? 0 : 1;
      end
      if (m_v[0]) return 0;
      if (m_v[1]) return 1;
      return -1;
   endfunction

   initial begin
      logic a_hold, l_hold;
      logic [23:0] ebv;
      int g;
      logic r0, r1;

      // Directed vectors: each row captured on one edge, checked just after it.
      tbl.push_back(mk(1,5,'h00ABCD, 0,0,0,       5,3,  1,5,'h00ABCD, 1,1, 1<<5,          1,0,0));
      tbl.push_back(mk(0,0,0,        0,0,0,       5,5,  0,0,'h00ABCD, 1,1, 0,             0,0,0));
      tbl.push_back(mk(1,7,'hAAAAAA, 1,8,'hBBBBBB, 7,8, 1,8,'hBBBBBB, 0,1, (1<<7)|(1<<8), 1,1,0));
      tbl.push_back(mk(0,0,0,        1,7,'hCCCCCC, 7,8, 1,7,'hAAAAAA, 1,0, 1<<7,          1,0,0));
      tbl.push_back(mk(0,0,0,        0,0,0,       7,30, 1,7,'hCCCCCC, 1,1, 1<<7,          1,0,0));
      tbl.push_back(mk(0,0,0,        0,0,0,       0,0,  0,0,'hCCCCCC, 1,1, 0,             0,0,0));
      tbl.push_back(mk(1,7,'h222222, 1,7,'h111111, 7,0, 1,7,'h111111, 0,1, 1<<7,          1,0,0));
      tbl.push_back(mk(0,0,0,        0,0,0,       7,0,  1,7,'h222222, 1,1, 1<<7,          1,0,0));
      tbl.push_back(mk(0,0,0,        0,0,0,       7,0,  0,0,'h222222, 1,1, 0,             0,0,0));
      tbl.push_back(mk(0,0,0,        1,7,'h111111, 7,0, 1,7,'h111111, 1,1, 1<<7,          1,0,0));
      tbl.push_back(mk(1,7,'h222222, 0,0,0,       7,0,  1,7,'h222222, 1,1, 1<<7,          1,0,0));
      tbl.push_back(mk(0,0,0,        0,0,0,       7,0,  0,0,'h222222, 1,1, 0,             0,0,0));
      tbl.push_back(mk(1,3,'h333333, 1,4,'h444444, 4,30, 1,4,'h444444, 0,1, (1<<3)|(1<<4), 1,0,0));
      tbl.push_back(mk(0,0,0,        0,0,0,       3,4,  1,3,'h333333, 1,1, 1<<3,          1,0,0));
      tbl.push_back(mk(0,0,0,        0,0,0,       3,4,  0,0,'h333333, 1,1, 0,             0,0,0));
      tbl.push_back(mk(0,0,0,        1,24,'h555555, 0,0, 0,0,'h333333, 1,1, 0,            0,0,1));
      tbl.push_back(mk(0,0,0,        0,0,0,       31,31, 0,0,'h333333, 1,1, 0,            0,0,1));

      // Reset state.
      #1;
      check_all("reset", 0, 0, 0, 1, 1, 0, 0, 0, 0);
      @(negedge Clock);
      Reset_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge Clock);
         AluValid = tbl[i].av; AluRd = tbl[i].ar; AluData = tbl[i].ad;
         LdValid = tbl[i].lv;  LdRd = tbl[i].lr;  LdData = tbl[i].ld;
         QueryRS = tbl[i].qs;  QueryRT = tbl[i].qt;
         @(posedge Clock);
         #1;
         check_all($sformatf("vec%0d", i), tbl[i].we, tbl[i].erd, tbl[i].ewd, tbl[i].ear,
                   tbl[i].elr, tbl[i].ebv, tbl[i].ebs, tbl[i].ebt, tbl[i].ebad);
      end

      // Both producers stream: Load wins 3 cycles, then the ALU once.
      @(negedge Clock);
      AluValid = 1'b1; AluRd = 5'd1; AluData = 24'hA1A1A1;
      LdValid = 1'b1;  LdRd = 5'd2;  LdData = 24'hB2B2B2;
      for (int c = 1; c <= 12; c++) begin
         @(posedge Clock);
         #1;
         chk($sformatf("starve c%0d RegWrite", c), 32'(RegWrite), 32'd1);
         chk($sformatf("starve c%0d RD", c), 32'(RD), (c % 4 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("starve c%0d LdReady", c), 32'(LdReady), (c % 4 == 0) ? 32'd0 : 32'd1);
      end
      @(negedge Clock);
      idle_inputs();
      repeat (3) @(negedge Clock);

      // Reset with both buffers freshly held; neither value may ever be written.
      AluValid = 1'b1; AluRd = 5'd10; AluData = 24'hDEAD01;
      LdValid = 1'b1;  LdRd = 5'd11;  LdData = 24'hDEAD02;
      @(posedge Clock);
      #1;
      Reset_n = 1'b0;
      idle_inputs();
      #1;
      check_all("midreset", 0, 0, 0, 1, 1, 0, 0, 0, 0);
      @(negedge Clock);
      Reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge Clock);
         #1;
         check_all($sformatf("postreset%0d", c), 0, 0, 0, 1, 1, 0, 0, 0, 0);
      end

      // Random traffic against the reference model.
      do_reset();
      for (int i = 0; i < 2; i++) begin
         m_v[i] = 1'b0; m_rd[i] = '0; m_dat[i] = '0; m_seq[i] = 0;
      end
      m_next_seq = 1; m_starve = 0; m_wd = '0; m_bad = 1'b0;
      a_hold = 1'b0; l_hold = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge Clock);
         if (!a_hold) begin
            AluValid = ($urandom_range(0, 2) != 0);
            AluRd = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 5));
            AluData = 24'($urandom);
         end
         if (!l_hold) begin
            LdValid = ($urandom_range(0, 2) != 0);
            LdRd = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 5));
            LdData = 24'($urandom);
         end
         QueryRS = 5'($urandom_range(0, 31));
         QueryRT = 5'($urandom_range(0, 7));
         #1;
         g = model_grant();
         r0 = !m_v[0] || (g == 0);
         r1 = !m_v[1] || (g == 1);
         ebv = '0;
         for (int s = 0; s < 2; s++) if (m_v[s]) ebv[m_rd[s]] = 1'b1;
         check_all($sformatf("rnd%0d", cyc), g >= 0,
                   (g >= 0) ? m_rd[g] : 5'd0, (g >= 0) ? m_dat[g] : m_wd, r0, r1, ebv,
                   (QueryRS < 24) ? ebv[QueryRS] : 1'b0, (QueryRT < 24) ? ebv[QueryRT] : 1'b0,
                   m_bad);
         // Advance model to the state after the coming edge.
         if (m_v[0] && g != 0) m_starve = (m_starve < 3) ? m_starve + 1 : 3;
         else m_starve = 0;
         if (g >= 0) begin
            m_wd = m_dat[g];
            m_v[g] = 1'b0;
         end
         if (LdValid && r1) begin
            if (LdRd >= 24) m_bad = 1'b1;
            m_v[1] = (LdRd < 24); m_rd[1] = LdRd; m_dat[1] = LdData; m_seq[1] = m_next_seq++;
         end
         if (AluValid && r0) begin
            if (AluRd >= 24) m_bad = 1'b1;
            m_v[0] = (AluRd < 24); m_rd[0] = AluRd; m_dat[0] = AluData; m_seq[0] = m_next_seq++;
         end
         a_hold = AluValid && !r0;
         l_hold = LdValid && !r1;
      end

      @(negedge Clock);
      idle_inputs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
